// File: rtl/CpuPkg.sv
// rtl/CpuPkg.sv - shared CPU data types and constants used by the fetch path
package CpuPkg;

  typedef logic [31:0] type_CpuData;
  typedef logic [4:0]  type_RegAddr;

  typedef struct packed {
    type_CpuData ins;
    type_CpuData pc;
  } type_FetchEntry;

  localparam int unsigned INS_BYTES = 4;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order instruction buffer with push, pop, flush and occupancy count
module fetch_queue
  import CpuPkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  type_FetchEntry pushEntry,
  input  logic           pop,
  input  logic           flush,
  output logic           headValid,
  output type_FetchEntry headEntry,
  output logic [CW-1:0]  count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  type_FetchEntry mem [DEPTH];
  logic [PW-1:0]  rdPtr;
  logic [PW-1:0]  wrPtr;
  logic           doPop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign headValid = (count != '0);
  assign headEntry = mem[rdPtr];
  assign doPop     = pop && headValid;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= pushEntry;
        wrPtr      <= nextPtr(wrPtr);
      end
      if (doPop) rdPtr <= nextPtr(rdPtr);
      count <= count + CW'(push) - CW'(doPop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, credit-limited imem requests, redirect flush and stale-response discard
module fetch_unit
  import CpuPkg::*;
#(
  parameter type_CpuData RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReq,
  output type_CpuData imemAddr,
  input  logic        imemGnt,
  input  logic        imemRvalid,
  input  type_CpuData imemRdata,
  output logic        insValid,
  output type_CpuData ins,
  output type_CpuData insPc,
  input  logic        insReady,
  input  logic        redirect,
  input  type_CpuData redirectPc,
  output logic        fetchFault
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  type_CpuData    pc;
  type_CpuData    streamPc;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  discard;
  logic [CW-1:0]  count;
  logic [CW-1:0]  outNext;
  logic [CW:0]    credit;
  logic           fault;
  logic           gnt;
  logic           pop;
  logic           push;
  logic           misaligned;
  type_FetchEntry pushEntry;
  type_FetchEntry headEntry;

  // Every granted word already owns a queue slot, so responses can never overflow the queue.
  assign pop        = insValid && insReady;
  assign credit     = {1'b0, outstanding} + {1'b0, count} - (CW+1)'(pop);
  assign imemReq    = !rst && !fault && (credit < (CW+1)'(QUEUE_DEPTH));
  assign gnt        = imemReq && imemGnt;
  assign outNext    = outstanding + CW'(gnt) - CW'(imemRvalid);
  assign push       = imemRvalid && (discard == '0) && !redirect;
  assign misaligned = (redirectPc[1:0] != 2'b00);
  assign pushEntry  = '{ins: imemRdata, pc: streamPc};

  assign imemAddr   = pc;
  assign fetchFault = fault;
  assign ins        = headEntry.ins;
  assign insPc      = headEntry.pc;

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pushEntry(pushEntry),
    .pop      (pop),
    .flush    (redirect),
    .headValid(insValid),
    .headEntry(headEntry),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      streamPc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      fault       <= 1'b0;
    end else begin
      outstanding <= outNext;
      if (redirect) begin
        // Everything still in flight, including a grant taken this cycle, is old-stream.
        pc       <= redirectPc;
        streamPc <= redirectPc;
        discard  <= outNext;
        fault    <= misaligned;
      end else begin
        if (gnt) pc <= pc + type_CpuData'(INS_BYTES);
        if (push) streamPc <= streamPc + type_CpuData'(INS_BYTES);
        if (imemRvalid && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the decoder. It owns the fetch PC and issues word requests to instruction memory over a request/grant plus response-valid protocol. Returned words are buffered in a small in-order queue and presented to the decoder with a valid/ready handshake. The unit redirects on branch/jump resolution and discards responses still in flight from the old stream.

## Interface
Parameters:
- RESET_PC, default 32'h0000_0000: PC fetched first after reset; must be word-aligned.
- QUEUE_DEPTH, default 2: instruction queue entries, and also the cap on outstanding plus buffered words. Minimum value 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imemReq  out  1  fetch request valid.
- imemAddr  out  32  word-aligned fetch address (type_CpuData).
- imemGnt  in  1  memory accepts the request this cycle.
- imemRvalid  in  1  response valid; responses return in order, at least 1 cycle after grant.
- imemRdata  in  32  response instruction word.
- insValid  out  1  the queue head is valid.
- ins  out  32  queue-head instruction, routed to the decoder ins input.
- insPc  out  32  PC of the queue-head instruction.
- insReady  in  1  decoder/downstream accepts the head.
- redirect  in  1  taken branch or jump resolved.
- redirectPc  in  32  new fetch PC.
- fetchFault  out  1  sticky flag: the last redirect target was misaligned.

## Operation
- State:
  - pc: next address to request.
  - outstanding: granted requests whose response has not yet returned.
  - discard: number of stale responses still to drop.
  - queue: data and PC per entry, with a count.
  - fault bit.
- Issue rule: imemReq = !fault && (outstanding + count − pop) < QUEUE_DEPTH.
  - pop = insValid && insReady.
  - This credit rule guarantees that every response has a free queue slot.
- On imemReq && imemGnt: pc += 4 (wraps modulo 2^32); outstanding increments.
- While imemReq is high and not granted, imemAddr is held stable. The only exception is a redirect.
- On imemRvalid: outstanding decrements.
  - If discard > 0, discard decrements and the word is dropped.
  - Otherwise the word is pushed with its PC. Queued PCs follow the stream counter, not imemAddr.
- redirect:
  - Queue flushes (count = 0).
  - discard ← outstanding after this cycle's grant and response are accounted for.
  - pc ← redirectPc.
  - A pop in the same cycle completes first; the flush then applies.
  - A response arriving in the same cycle is discarded.
  - A request granted in the same cycle belongs to the old stream and is added to discard.
  - A pending ungranted request is withdrawn. Instruction memory tolerates withdrawal of an ungranted request.
- Misaligned redirect (redirectPc[1:0] != 0):
  - Flush as above, set fault, and stop issuing.
  - insValid stays 0.
  - The next aligned redirect clears fault and resumes fetch.
- discard and outstanding never exceed QUEUE_DEPTH.
- Counters are $clog2(QUEUE_DEPTH+1) bits wide.

## Timing
- Reset values:
  - imemReq=0, imemAddr=RESET_PC, insValid=0, ins=0, insPc=0, fetchFault=0.
  - pc=RESET_PC; outstanding=discard=count=0.
- First request: the first cycle after rst deasserts.
- Latency with zero-wait memory (grant in cycle n, rvalid in n+1): insValid asserts in n+2. The queue output is registered; there is no bypass.
- Throughput: 1 instruction/cycle sustained while insReady=1, QUEUE_DEPTH≥2 and memory latency is 1 cycle.
- Redirect to first new instruction:
  - Request goes out in the cycle after the redirect.
  - insValid asserts 2 cycles after that request is granted.
  - This holds only once every stale response has drained.
- Handshake:
  - ins and insPc are stable while insValid && !insReady.
  - insValid never drops without a pop, except on redirect or rst.
- rst mid-operation overrides everything: in-flight responses after rst are not expected, since memory is reset together with the unit.

## Structure
- CpuPkg holds:
  - the type_CpuData and type_RegAddr reuse;
  - a new type_FetchEntry struct (ins, pc);
  - constant INS_BYTES = 4.
- One natural sub-module: fetch_queue, a parameterised synchronous FIFO with push, pop, flush and count.
- fetch_unit contains the PC, the credit counters, the discard counter and the fault logic.

## Test plan
- Reset release, zero-wait memory returning addr^32'hA5A5_0000 → imemAddr sequence 0,4,8,…; insPc/ins pairs match; insValid first asserts in cycle 2; then 1 instruction/cycle.
- insReady=0 for 10 cycles → at most QUEUE_DEPTH words buffered/outstanding; imemReq deasserts; head stable; no words lost after release.
- Grant withheld 3 cycles → imemAddr constant; pc not advanced; no duplicate fetch.
- Redirect to 0x100 with 2 responses in flight (3-cycle latency) → both dropped; first delivered insPc=0x100; no old-stream word delivered.
- Redirect to 0x102 → fetchFault=1, imemReq=0, insValid=0; then redirect to 0x200 → fault clears, fetch resumes at 0x200.
- Same cycle pop + redirect + rvalid + grant → popped word accepted once; response and granted request discarded; next delivered insPc=redirectPc.
